// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin arbiter sharing one spi_master among NUM_REQ clients
module spi_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]              o_ack,
  output logic [DATA_WIDTH-1:0]           o_rsp_data,
  output logic                            o_busy,
  output logic [$clog2(NUM_REQ)-1:0]      o_owner,
  output logic                            o_m_start,
  output logic [DATA_WIDTH-1:0]           o_m_mosi_data,
  input  logic [DATA_WIDTH-1:0]           i_m_miso_data,
  input  logic                            i_m_done,
  input  logic                            i_m_cs_n,
  output logic [NUM_REQ-1:0]              o_ss_n
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_RELEASE
  } state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_rr_ptr;
  logic [IW-1:0]           r_owner;
  logic [NUM_REQ-1:0]      r_ack;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic                    r_busy;
  logic                    r_m_start;
  logic [DATA_WIDTH-1:0]   r_m_mosi_data;

  logic                    w_found;
  logic [IW-1:0]           w_winner;
  logic [DATA_WIDTH-1:0]   w_winner_data;
  logic [IW-1:0]           w_next_ptr;
  logic [NUM_REQ-1:0]      w_owner_onehot;

  // Client index at a given offset above the round-robin pointer, wrapped mod NUM_REQ.
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IW'(sum);
  endfunction

  // Round-robin pick: scan offsets high to low so the smallest offset from the pointer wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[rr_idx(r_rr_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = rr_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_winner_data  = i_req_data[w_winner*DATA_WIDTH +: DATA_WIDTH];
  assign w_next_ptr     = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;

  // Handshake sequencer: grant, launch the master, wait for done, ack the owner, wait for master idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_ack         <= '0;
      r_rsp_data    <= '0;
      r_busy        <= 1'b0;
      r_m_start     <= 1'b0;
      r_m_mosi_data <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner       <= w_winner;
            r_m_mosi_data <= w_winner_data;
            r_m_start     <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_LAUNCH;
          end else begin
            r_m_start <= 1'b0;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_m_done) begin
            r_rsp_data <= i_m_miso_data;
            r_ack      <= w_owner_onehot;
            r_m_start  <= 1'b0;
            r_rr_ptr   <= w_next_ptr;
            r_state    <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!i_m_done) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Only the owner's select may follow the master's chip select, and only while a transfer is owned.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ss
    assign o_ss_n[g] = i_m_cs_n | (r_owner != IW'(g)) | ~r_busy;
  end

  assign o_ack         = r_ack;
  assign o_rsp_data    = r_rsp_data;
  assign o_busy        = r_busy;
  assign o_owner       = r_owner;
  assign o_m_start     = r_m_start;
  assign o_m_mosi_data = r_m_mosi_data;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb/tb_spi_req_arbiter.sv - scoreboard bench for spi_req_arbiter with a behavioural spi_master and slaves
module tb_spi_req_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rsp_data;
  logic            busy;
  logic [1:0]      owner;
  logic            m_start;
  logic [DW-1:0]   m_mosi_data;
  logic [DW-1:0]   m_miso_data;
  logic            m_done;
  logic            m_cs_n;
  logic [N-1:0]    ss_n;

  always #5 clk = ~clk;

  spi_req_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req         (req),
    .i_req_data    (req_data),
    .o_ack         (ack),
    .o_rsp_data    (rsp_data),
    .o_busy        (busy),
    .o_owner       (owner),
    .o_m_start     (m_start),
    .o_m_mosi_data (m_mosi_data),
    .i_m_miso_data (m_miso_data),
    .i_m_done      (m_done),
    .i_m_cs_n      (m_cs_n),
    .o_ss_n        (ss_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] slave_reply(input int i);
    return 8'h2C ^ 8'(i << 4);
  endfunction

  // MISO bit driven by whichever single slave is selected; nothing (0) otherwise.
  function automatic logic miso_of(input logic [N-1:0] ss, input int c);
    int n;
    int idx;
    logic [7:0] r;
    n = 0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      if (!ss[i]) begin
        n++;
        idx = i;
      end
    end
    if (n != 1) return 1'b0;
    r = slave_reply(idx);
    return r[7-c];
  endfunction

  // Behavioural spi_master: 8 bit clocks MSB first, done held while start stays high.
  int         m_state;
  int         m_cnt;
  logic [7:0] m_tx;
  logic [7:0] m_rxsh;
  logic [7:0] m_mosish;
  logic [7:0] slave_rx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state     <= 0;
      m_cnt       <= 0;
      m_done      <= 1'b0;
      m_cs_n      <= 1'b1;
      m_miso_data <= '0;
      m_tx        <= '0;
      m_rxsh      <= '0;
      m_mosish    <= '0;
    end else begin
      case (m_state)
        0: if (m_start) begin
          m_tx    <= m_mosi_data;
          m_cs_n  <= 1'b0;
          m_cnt   <= 0;
          m_state <= 1;
        end
        1: begin
          m_mosish <= {m_mosish[6:0], m_tx[7-m_cnt]};
          m_rxsh   <= {m_rxsh[6:0], miso_of(ss_n, m_cnt)};
          if (m_cnt == 7) begin
            m_miso_data <= {m_rxsh[6:0], miso_of(ss_n, m_cnt)};
            slave_rx    <= {m_mosish[6:0], m_tx[7-m_cnt]};
            m_done      <= 1'b1;
            m_cs_n      <= 1'b1;
            m_state     <= 2;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        default: if (!m_start) begin
          m_done  <= 1'b0;
          m_state <= 0;
        end
      endcase
    end
  end

  typedef struct {
    int         client;
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  exp_t            sb_q[$];
  int              order_q[$];
  int              model_ptr = 0;
  logic [N-1:0]    req_at_edge;
  logic [N*DW-1:0] data_at_edge;
  int              last_gap = 0;
  int              issued[N];
  int              served[N];

  always @(posedge clk) begin
    req_at_edge  <= req;
    data_at_edge <= req_data;
  end

  // Client model: hold req until ack, drop it for one cycle, re-raise while transfers remain.
  initial begin
    bit cool[N];
    for (int i = 0; i < N; i++) cool[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          req[i]    = 1'b0;
          served[i] = served[i] + 1;
          cool[i]   = 1'b1;
        end else if (cool[i]) begin
          cool[i] = 1'b0;
        end else if (!req[i] && issued[i] > served[i]) begin
          req[i] = 1'b1;
        end
      end
    end
  end

  // Monitor: predict each grant from the sampled requests, score every ack against the prediction.
  initial begin
    logic         prev_start, prev_done, prev_cs_n, done_rose, had_grant, f;
    logic [N-1:0] prev_ack, exp_vec;
    int           gap, w, ack_idx;
    exp_t         e;
    prev_start = 0; prev_done = 0; prev_cs_n = 1; done_rose = 0; had_grant = 0;
    prev_ack = '0; gap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        model_ptr = 0;
        prev_start = 0; prev_done = 0; prev_cs_n = 1; done_rose = 0; had_grant = 0;
        prev_ack = '0; gap = 0;
      end else begin
        if (m_start && !prev_start) begin
          f = 0;
          w = 0;
          for (int k = N - 1; k >= 0; k--) begin
            if (req_at_edge[(model_ptr + k) % N]) begin
              f = 1;
              w = (model_ptr + k) % N;
            end
          end
          check_eq("grant_has_request", 32'(f), 32'd1);
          if (had_grant) check_eq("start_low_gap_ge2", 32'(gap >= 2), 32'd1);
          last_gap  = gap;
          had_grant = 1;
          e.client  = w;
          e.tx      = data_at_edge[w*DW +: DW];
          e.rx      = slave_reply(w);
          sb_q.push_back(e);
          model_ptr = (w + 1) % N;
        end
        gap = m_start ? 0 : gap + 1;
        if (!m_cs_n && prev_cs_n && sb_q.size() > 0) begin
          exp_vec = ~(4'b0001 << sb_q[0].client);
          check_eq("ss_n_owner_only", 32'(ss_n), 32'(exp_vec));
        end
        if (done_rose) check_eq("ack_one_cycle_after_done", 32'(ack != 0), 32'd1);
        done_rose = m_done && !prev_done;
        if (ack != 0) begin
          check_eq("ack_single_cycle_pulse", 32'(prev_ack), 32'd0);
          ack_idx = -1;
          for (int i = 0; i < N; i++) if (ack[i]) ack_idx = i;
          order_q.push_back(ack_idx);
          if (sb_q.size() == 0) begin
            check_eq("ack_without_grant", 32'(ack), 32'd0);
          end else begin
            e = sb_q.pop_front();
            exp_vec = 4'b0001 << e.client;
            check_eq("ack_onehot", 32'(ack), 32'(exp_vec));
            check_eq("rsp_data", 32'(rsp_data), 32'(e.rx));
            check_eq("owner", 32'(owner), 32'(e.client));
            check_eq("slave_rx_word", 32'(slave_rx), 32'(e.tx));
          end
        end
        prev_start = m_start;
        prev_done  = m_done;
        prev_cs_n  = m_cs_n;
        prev_ack   = ack;
      end
    end
  end

  task automatic wait_quiet(input string tag);
    int cyc;
    bit q;
    cyc = 0;
    q = 0;
    while (!q && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      q = !busy && req == '0 && m_state == 0;
      for (int i = 0; i < N; i++) if (issued[i] != served[i]) q = 0;
    end
    check_eq({tag, "_completes"}, 32'(q), 32'd1);
    check_eq({tag, "_scoreboard_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_cs_low(input string tag);
    int cyc;
    cyc = 0;
    while (m_cs_n && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_cs_low_seen"}, 32'(m_cs_n), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_order(input string tag, input int exp_list[$]);
    check_eq({tag, "_grant_count"}, 32'(order_q.size()), 32'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && i < order_q.size(); i++)
      check_eq({tag, "_grant_order"}, 32'(order_q[i]), 32'(exp_list[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      issued[i] = 0;
      served[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_eq("reset_ack", 32'(ack), 32'd0);
    check_eq("reset_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_owner", 32'(owner), 32'd0);
    check_eq("reset_m_start", 32'(m_start), 32'd0);
    check_eq("reset_m_mosi_data", 32'(m_mosi_data), 32'd0);
    check_eq("reset_ss_n", 32'(ss_n), 32'hF);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_no_start", 32'(m_start), 32'd0);

    // 1: single transfer for client 1
    req_data[1*DW +: DW] = 8'hA5;
    issued[1]++;
    wait_quiet("t1");
    check_order("t1", '{1});
    check_eq("t1_mosi_stream", 32'(slave_rx), 32'hA5);
    check_eq("t1_rsp_data_held", 32'(rsp_data), 32'h3C);
    check_eq("t1_ss_n_idle", 32'(ss_n), 32'hF);

    // 2: all four requesting from pointer 0, client 0 asks twice
    apply_reset();
    order_q.delete();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    issued[0] += 2;
    issued[1]++;
    issued[2]++;
    issued[3]++;
    wait_quiet("t2");
    check_order("t2", '{0, 1, 2, 3, 0});

    // 3: pointer wrap after a grant to client 3
    order_q.delete();
    issued[3]++;
    wait_quiet("t3a");
    issued[0]++;
    issued[3]++;
    wait_quiet("t3b");
    check_order("t3", '{3, 0, 3});

    // 4: client 2 arrives while client 0 is mid-transfer
    order_q.delete();
    issued[0]++;
    wait_cs_low("t4");
    issued[2]++;
    wait_quiet("t4");
    check_order("t4", '{0, 2});
    check_eq("t4_start_gap_ge2", 32'(last_gap >= 2), 32'd1);

    // 5: TX word changed after grant is not sent
    order_q.delete();
    req_data[0*DW +: DW] = 8'h11;
    issued[0]++;
    wait_cs_low("t5");
    req_data[0*DW +: DW] = 8'hFF;
    wait_quiet("t5");
    check_eq("t5_slave_rx", 32'(slave_rx), 32'h11);
    check_eq("t5_rsp_data", 32'(rsp_data), 32'(slave_reply(0)));

    // 6: reset during WAIT_DONE, then re-grant from pointer 0
    issued[1]++;
    wait_quiet("t6a");
    order_q.delete();
    issued[0]++;
    issued[2]++;
    wait_cs_low("t6");
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_reset_m_start", 32'(m_start), 32'd0);
    check_eq("t6_reset_busy", 32'(busy), 32'd0);
    check_eq("t6_reset_ack", 32'(ack), 32'd0);
    check_eq("t6_reset_ss_n", 32'(ss_n), 32'hF);
    check_eq("t6_reset_owner", 32'(owner), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_quiet("t6b");
    check_order("t6", '{0, 2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
